cpu_log_serializer: RTL and testbench

CPU_LOG_SERIALIZER -- requirements
Module: cpu_log_serializer

---
 rtl/cpu_log_serializer.sv | 138 +++++++++++++
 tb/tb_cpu_log_serializer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_log_serializer.sv
// Serializes CPU register/memory write records into an ASCII log frame, one char per cycle.
// Optional CPU_LOG_SPACES_EN macro inserts readability spaces around ':' / '<=' tokens.
module cpu_log_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_kind,
  input  logic [15:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_dst,
  input  logic [31:0] in_data,
  output logic [7:0]  char,
  output logic        done,
  output logic        busy
);

`ifdef CPU_LOG_SPACES_EN
  localparam logic [5:0] SP6 = 6'd1;
`else
  localparam logic [5:0] SP6 = 6'd0;
`endif

  localparam logic [5:0] P_KIND = 6'd15 + SP6;
  localparam logic [5:0] P_DST  = 6'd16 + SP6;

  typedef enum logic {IDLE, EMIT} state_t;

  typedef struct packed {
    logic        kind;
    logic [15:0] tim;
    logic [31:0] pc;
    logic [31:0] dst;
    logic [31:0] data;
  } rec_t;

  state_t     state;
  rec_t       rec;
  logic [5:0] idx;
  logic       accept;

  logic [5:0] dl, p_dend, p_lt, p_eq, p_dat, p_hash;
  logic [5:0] off_t, off_p, off_d, off_v;
  logic [7:0] nxt_ch;

  // Ready in IDLE, and on the '#' cycle so the next frame can follow without a gap.
  assign in_ready = (state == IDLE) | done;
  assign accept   = in_valid & in_ready;

  function automatic logic [3:0] nib32(input logic [31:0] w, input logic [2:0] k);
    logic [31:0] s;
    s = w >> {~k, 2'b00};
    return s[3:0];
  endfunction

  function automatic logic [3:0] nib16(input logic [15:0] w, input logic [1:0] k);
    logic [15:0] s;
    s = w >> {~k, 2'b00};
    return s[3:0];
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Non-BCD time digits become '?' so the downstream checker rejects the frame.
  function automatic logic [7:0] bcd_char(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
  endfunction

  function automatic logic [7:0] dec_char(input logic [4:0] v, input logic ones);
    logic [4:0] t, o;
    if (v >= 5'd30)      t = 5'd3;
    else if (v >= 5'd20) t = 5'd2;
    else if (v >= 5'd10) t = 5'd1;
    else                 t = 5'd0;
    o = v - (t * 5'd10);
    return ones ? (8'h30 + {3'b000, o}) : (8'h30 + {3'b000, t});
  endfunction

  // Character for frame position idx, derived from the latched record.
  always_comb begin
    dl     = rec.kind ? 6'd8 : 6'd2;
    p_dend = P_DST + dl;
    p_lt   = p_dend + SP6;
    p_eq   = p_lt + 6'd1;
    p_dat  = p_eq + 6'd1 + SP6;
    p_hash = p_dat + 6'd8;
    off_t  = idx - 6'd1;
    off_p  = idx - 6'd6;
    off_d  = idx - P_DST;
    off_v  = idx - p_dat;
    nxt_ch = 8'h20;
    if (idx == 6'd0)                        nxt_ch = "^";
    else if (idx <= 6'd4)                   nxt_ch = bcd_char(nib16(rec.tim, off_t[1:0]));
    else if (idx == 6'd5)                   nxt_ch = "@";
    else if (idx <= 6'd13)                  nxt_ch = hex_char(nib32(rec.pc, off_p[2:0]));
    else if (idx == 6'd14)                  nxt_ch = ":";
    else if (idx == P_KIND)                 nxt_ch = rec.kind ? "*" : "$";
    else if (idx >= P_DST && idx < p_dend)
      nxt_ch = rec.kind ? hex_char(nib32(rec.dst, off_d[2:0])) : dec_char(rec.dst[4:0], off_d[0]);
    else if (idx == p_lt)                   nxt_ch = "<";
    else if (idx == p_eq)                   nxt_ch = "=";
    else if (idx >= p_dat && idx < p_hash)  nxt_ch = hex_char(nib32(rec.data, off_v[2:0]));
    else if (idx == p_hash)                 nxt_ch = "#";
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rec   <= '0;
      idx   <= 6'd0;
      char  <= 8'h20;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else if (accept) begin
      state <= EMIT;
      busy  <= 1'b1;
      rec   <= '{kind: in_kind, tim: in_time, pc: in_pc, dst: in_dst, data: in_data};
      char  <= "^";
      idx   <= 6'd1;
      done  <= 1'b0;
    end else if (state == EMIT) begin
      if (done) begin
        state <= IDLE;
        busy  <= 1'b0;
        char  <= 8'h20;
        idx   <= 6'd0;
        done  <= 1'b0;
      end else begin
        char  <= nxt_ch;
        idx   <= idx + 6'd1;
        done  <= (idx == p_hash);
      end
    end
  end

endmodule

// File: tb/tb_cpu_log_serializer.sv
// Randomized bench for cpu_log_serializer against a string-level frame model.
module tb_cpu_log_serializer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_kind = 1'b0;
  logic [15:0] in_time = '0;
  logic [31:0] in_pc = '0, in_dst = '0, in_data = '0;
  logic [7:0]  char;
  logic        done, busy;

  int checks = 0;
  int errors = 0;

`ifdef CPU_LOG_SPACES_EN
  localparam bit SP = 1'b1;
`else
  localparam bit SP = 1'b0;
`endif

  cpu_log_serializer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_time(in_time), .in_pc(in_pc), .in_dst(in_dst),
    .in_data(in_data), .char(char), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic string tdig(input logic [3:0] n);
    return (n > 4'd9) ? "?" : $sformatf("%0d", n);
  endfunction

  function automatic string model(input bit k, input logic [15:0] t,
                                  input logic [31:0] p, input logic [31:0] d, input logic [31:0] v);
    string s, sp;
    sp = SP ? " " : "";
    s = {"^", tdig(t[15:12]), tdig(t[11:8]), tdig(t[7:4]), tdig(t[3:0]), "@",
         $sformatf("%08h", p), ":", sp};
    if (k) s = {s, "*", $sformatf("%08h", d)};
    else   s = {s, "$", $sformatf("%02d", int'(d[4:0]))};
    s = {s, sp, "<=", sp, $sformatf("%08h", v), "#"};
    return s;
  endfunction

  function automatic string pulse(input int len);
    string s;
    s = "";
    for (int i = 0; i < len - 1; i++) s = {s, "0"};
    return {s, "1"};
  endfunction

  function automatic string ones(input int len);
    string s;
    s = "";
    for (int i = 0; i < len; i++) s = {s, "1"};
    return s;
  endfunction

  // Presents one record, scrambles inputs after acceptance, and records per-cycle outputs.
  task automatic run_frame(input bit k, input logic [15:0] t, input logic [31:0] p,
                           input logic [31:0] d, input logic [31:0] v,
                           output string ch, output string dn, output string bs,
                           output string rd, output logic [7:0] post);
    int w;
    ch = ""; dn = ""; bs = ""; rd = "";
    @(negedge clk);
    in_valid = 1'b1; in_kind = k; in_time = t; in_pc = p; in_dst = d; in_data = v;
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_kind = 1'($urandom_range(0, 1)); in_time = 16'($urandom);
    in_pc = $urandom; in_dst = $urandom; in_data = $urandom;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ch = {ch, $sformatf("%c", char)};
      dn = {dn, $sformatf("%0d", done)};
      bs = {bs, $sformatf("%0d", busy)};
      rd = {rd, $sformatf("%0d", in_ready)};
      if (char == "#") break;
    end
    @(negedge clk);
    post = char;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (char !== 8'h20 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: char=%h done=%b busy=%b, want 20/0/0", char, done, busy);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (char !== 8'h20 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_filler: char=%h busy=%b, want 20/0", char, busy);
    end
  endtask

  task automatic check_frame(input string name, input string exp, input string ch,
                             input string dn, input string bs, input string rd, input logic [7:0] post);
    checks++;
    if (ch != exp) begin errors++; $display("FAIL %s chars: got \"%s\" want \"%s\"", name, ch, exp); end
    checks++;
    if (dn != pulse(exp.len())) begin errors++; $display("FAIL %s done: got %s want %s", name, dn, pulse(exp.len())); end
    checks++;
    if (rd != pulse(exp.len())) begin errors++; $display("FAIL %s ready: got %s want %s", name, rd, pulse(exp.len())); end
    checks++;
    if (bs != ones(exp.len())) begin errors++; $display("FAIL %s busy: got %s want %s", name, bs, ones(exp.len())); end
    checks++;
    if (post !== 8'h20 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after: char=%h busy=%b want 20/0", name, post, busy);
    end
  endtask

  task automatic test_fixed();
    string ch, dn, bs, rd, lit;
    logic [7:0] post;
    run_frame(1'b0, 16'h0012, 32'h00003000, 32'd5, 32'h0000abcd, ch, dn, bs, rd, post);
    lit = SP ? "^0012@00003000: $05 <= 0000abcd#" : "^0012@00003000:$05<=0000abcd#";
    check_frame("reg_frame", lit, ch, dn, bs, rd, post);
    run_frame(1'b1, 16'h9999, 32'hdeadbeef, 32'h00000010, 32'hffffffff, ch, dn, bs, rd, post);
    lit = SP ? "^9999@deadbeef: *00000010 <= ffffffff#" : "^9999@deadbeef:*00000010<=ffffffff#";
    check_frame("mem_frame", lit, ch, dn, bs, rd, post);
    run_frame(1'b0, 16'h00a1, 32'h12345678, 32'hffffffff, 32'h0, ch, dn, bs, rd, post);
    lit = SP ? "^00?1@12345678: $31 <= 00000000#" : "^00?1@12345678:$31<=00000000#";
    check_frame("bad_time", lit, ch, dn, bs, rd, post);
  endtask

  task automatic test_random();
    string ch, dn, bs, rd;
    logic [7:0] post;
    bit k;
    logic [15:0] t;
    logic [31:0] p, d, v;
    for (int n = 0; n < 20; n++) begin
      k = 1'($urandom_range(0, 1));
      t = 16'($urandom);
      p = $urandom; d = $urandom; v = $urandom;
      run_frame(k, t, p, d, v, ch, dn, bs, rd, post);
      check_frame($sformatf("rand%0d", n), model(k, t, p, d, v), ch, dn, bs, rd, post);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    string ch, dn, rd, ea, eb;
    int hashes;
    logic [31:0] pb, db, vb;
    pb = $urandom; db = $urandom; vb = $urandom;
    ea = model(1'b1, 16'h2024, 32'hcafef00d, 32'h80001234, 32'h01234567);
    eb = model(1'b0, 16'h0731, pb, db, vb);
    ch = ""; dn = ""; rd = ""; hashes = 0;
    @(negedge clk);
    in_valid = 1'b1; in_kind = 1'b1; in_time = 16'h2024; in_pc = 32'hcafef00d;
    in_dst = 32'h80001234; in_data = 32'h01234567;
    @(posedge clk);
    #1;
    in_kind = 1'b0; in_time = 16'h0731; in_pc = pb; in_dst = db; in_data = vb;
    for (int i = 0; i < 100 && hashes < 2; i++) begin
      @(negedge clk);
      ch = {ch, $sformatf("%c", char)};
      dn = {dn, $sformatf("%0d", done)};
      rd = {rd, $sformatf("%0d", in_ready)};
      if (char == "#") begin
        hashes++;
        if (hashes == 1) begin @(posedge clk); #1; in_valid = 1'b0; end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (ch != {ea, eb}) begin errors++; $display("FAIL b2b chars: got \"%s\" want \"%s\"", ch, {ea, eb}); end
    checks++;
    if (rd != {pulse(ea.len()), pulse(eb.len())}) begin
      errors++; $display("FAIL b2b ready: got %s want %s", rd, {pulse(ea.len()), pulse(eb.len())});
    end
    checks++;
    if (dn != {pulse(ea.len()), pulse(eb.len())}) begin
      errors++; $display("FAIL b2b done: got %s want %s", dn, {pulse(ea.len()), pulse(eb.len())});
    end
    @(negedge clk);
    checks++;
    if (char !== 8'h20 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b idle: char=%h busy=%b want 20/0", char, busy);
    end
  endtask

  task automatic test_reset_mid();
    string ch, dn, bs, rd, exp, part;
    logic [7:0] post;
    logic [31:0] p, v;
    p = $urandom; v = $urandom;
    exp = model(1'b0, 16'h1234, p, 32'd17, v);
    part = "";
    @(negedge clk);
    in_valid = 1'b1; in_kind = 1'b0; in_time = 16'h1234; in_pc = p; in_dst = 32'd17; in_data = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      part = {part, $sformatf("%c", char)};
    end
    checks++;
    if (part != exp.substr(0, 10)) begin
      errors++; $display("FAIL mid_prefix: got \"%s\" want \"%s\"", part, exp.substr(0, 10));
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (char !== 8'h20 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_async: char=%h busy=%b done=%b want 20/0/0", char, busy, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_frame(1'b1, 16'h5678, p, v, p ^ v, ch, dn, bs, rd, post);
    check_frame("after_reset", model(1'b1, 16'h5678, p, v, p ^ v), ch, dn, bs, rd, post);
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
